// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: bus widths, ROM enable
// levels and the {pc, inst} layout of a fetch-queue entry.
package fetch_unit_pkg;

  localparam int          INST_ADDR_W  = 32;
  localparam int          INST_W       = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam int          FETCH_QDEPTH = 2;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fq_entry_t;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, inst} FIFO between the ROM capture stage and decode.
// Flush wins over push/pop; a push is accepted when full only if a pop frees a slot.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_QDEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t din,
  output fq_entry_t dout,
  output logic      empty,
  output logic      full
);

  fq_entry_t  r_mem [DEPTH];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;

  logic w_pop;
  logic w_push;

  assign empty  = (r_count == 2'd0);
  assign full   = (r_count == 2'd2);
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage carries no reset; the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push & ~flush) r_mem[r_tail] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the ROM from registers, and
// queues {pc, inst} pairs for decode with branch-redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = FETCH_QDEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  logic        r_ce;
  logic [31:0] r_pc;

  logic      w_pop;
  logic      w_space;
  logic      w_push;
  logic      w_empty;
  logic      w_full;
  fq_entry_t w_din;
  fq_entry_t w_head;

  assign w_pop   = valid_o & ready_i;
  assign w_space = ~w_full | w_pop;
  assign w_push  = r_ce & w_space & ~redirect_i;
  assign w_din   = {r_pc, rom_inst_i};

  // ce comes up one edge after reset release, so the first fetch of RESET_PC
  // happens in the cycle after that; a redirect may still retarget pc meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce <= CHIP_DISABLE;
      r_pc <= RESET_PC;
    end else begin
      r_ce <= CHIP_ENABLE;
      if (redirect_i)  r_pc <= word_align(redirect_pc_i);
      else if (w_push) r_pc <= r_pc + 32'd4;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop & ~redirect_i),
    .flush (redirect_i),
    .din   (w_din),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  assign rom_ce_o   = r_ce;
  assign rom_addr_o = r_pc;
  assign valid_o    = ~w_empty;
  assign pc_o       = valid_o ? w_head.pc   : ZERO_WORD;
  assign inst_o     = valid_o ? w_head.inst : ZERO_WORD;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based model of the fetch rules is compared
// on every falling edge, plus literal expectations at key points of each scenario.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_inst_i    (rom_inst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o)
  );

  // ROM contents: mem[i] = i + 0x100, for any word index.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr >> 2) + 32'h100;
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a PC, an enable flag and a queue of fetched PCs.
  logic [31:0] m_pc;
  logic        m_ce;
  logic [31:0] mq[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= 32'h0;
      m_ce <= 1'b0;
      mq.delete();
    end else begin
      bit do_pop;
      bit has_space;
      do_pop    = (mq.size() != 0) && ready_i;
      has_space = (mq.size() < 2) || do_pop;
      if (redirect_i) begin
        mq.delete();
        m_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (m_ce && has_space) begin
          mq.push_back(m_pc);
          m_pc <= m_pc + 32'd4;
        end
      end
      m_ce <= 1'b1;
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = (mq.size() != 0);
    chk("model_valid", {31'b0, valid_o}, {31'b0, ev});
    chk("model_pc", pc_o, ev ? mq[0] : 32'h0);
    chk("model_inst", inst_o, ev ? rom_word(mq[0]) : 32'h0);
    chk("model_ce", {31'b0, rom_ce_o}, {31'b0, m_ce});
    chk("model_addr", rom_addr_o, m_pc);
    if (valid_o && ready_i) $display("deliver pc=%h inst=%h", pc_o, inst_o);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Assert reset between edges, check the immediate effect, release and reach first valid.
  task automatic reset_release();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_ce", {31'b0, rom_ce_o}, 32'd0);
    chk("rst_addr", rom_addr_o, 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst_o", inst_o, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("start_ce", {31'b0, rom_ce_o}, 32'd1);
    chk("start_valid", {31'b0, valid_o}, 32'd0);
    chk("start_addr", rom_addr_o, 32'h0);
    tick();
    chk("first_valid", {31'b0, valid_o}, 32'd1);
    chk("first_pc", pc_o, 32'h0);
    chk("first_inst", inst_o, 32'h100);
  endtask

  task automatic stream3();
    tick(); chk("s_pc4", pc_o, 32'h4);  chk("s_inst101", inst_o, 32'h101);
    tick(); chk("s_pc8", pc_o, 32'h8);  chk("s_inst102", inst_o, 32'h102);
    tick(); chk("s_pc12", pc_o, 32'hC); chk("s_inst103", inst_o, 32'h103);
  endtask

  initial begin
    logic [31:0] last_pc;
    rst = 1'b0;
    ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;

    // Reset release and steady streaming
    reset_release();
    stream3();

    // Backpressure
    reset_release();
    ready_i = 1'b0;
    repeat (5) tick();
    chk("bp_valid", {31'b0, valid_o}, 32'd1);
    chk("bp_head", pc_o, 32'h0);
    chk("bp_addr", rom_addr_o, 32'h8);
    ready_i = 1'b1;
    tick(); chk("bp_pc4", pc_o, 32'h4);
    tick(); chk("bp_pc8", pc_o, 32'h8);

    // Redirect while full
    ready_i = 1'b0;
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0043;
    tick();
    redirect_i = 1'b0;
    chk("rd_valid0", {31'b0, valid_o}, 32'd0);
    chk("rd_addr", rom_addr_o, 32'h40);
    tick();
    chk("rd_valid1", {31'b0, valid_o}, 32'd1);
    chk("rd_pc", pc_o, 32'h40);
    chk("rd_inst", inst_o, 32'h110);

    // Push and pop together at full with ready toggling
    last_pc = 32'h3C;
    for (int i = 0; i < 12; i++) begin
      ready_i = i[0];
      if (valid_o && ready_i) begin
        chk("incr_pc", {31'b0, pc_o > last_pc}, 32'd1);
        last_pc = pc_o;
      end
      tick();
    end

    // Wrap-around
    ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("wr_valid0", {31'b0, valid_o}, 32'd0);
    tick(); chk("wr_pc_top", pc_o, 32'hFFFF_FFFC); chk("wr_inst_top", inst_o, 32'h4000_00FF);
    tick(); chk("wr_pc0", pc_o, 32'h0);           chk("wr_inst0", inst_o, 32'h100);
    tick(); chk("wr_pc4", pc_o, 32'h4);           chk("wr_inst4", inst_o, 32'h101);

    // Asynchronous reset mid-stream, then recovery
    tick();
    reset_release();
    stream3();

    // Redirect while ce is still low
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0080;
    tick();
    redirect_i = 1'b0;
    chk("ce0_addr", rom_addr_o, 32'h80);
    chk("ce0_ce", {31'b0, rom_ce_o}, 32'd1);
    tick();
    chk("ce0_pc", pc_o, 32'h80);
    chk("ce0_inst", inst_o, 32'h120);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end sitting directly upstream of the instruction ROM and downstream-facing to decode.
- Owns the program counter and drives the ROM's chip-enable and address.
- Captures the combinational ROM output in the same cycle, storing {pc, inst} in a 2-entry fetch queue.
- Presents queue entries to decode over a valid/ready handshake; supports branch redirect with queue flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- QDEPTH, 2, fetch-queue depth. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce_o  output  1  ROM chip enable (`ChipEnable/`ChipDisable).
- rom_addr_o  output  `InstAddrBus (32)  ROM byte address, equal to the current PC.
- rom_inst_i  input  `InstBus (32)  ROM instruction data, valid combinationally in the same cycle.
- redirect_i  input  1  branch/jump taken; flush the queue and load the new PC.
- redirect_pc_i  input  32  redirect target address.
- valid_o  output  1  queue head valid toward decode.
- ready_i  input  1  decode accepts the head this cycle.
- inst_o  output  32  head instruction; `ZeroWord when valid_o=0.
- pc_o  output  32  head PC; `ZeroWord when valid_o=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, ce_r=0, count=0, head/tail pointers=0.
  - All outputs: rom_ce_o=`ChipDisable, rom_addr_o=RESET_PC, valid_o=0, inst_o=pc_o=`ZeroWord.
- Start-up:
  - ce_r becomes 1 on the first rising edge after rst deasserts.
  - pc does not advance on that edge.
  - First fetch of RESET_PC occurs in the following cycle.
- ROM drive: rom_ce_o=ce_r and rom_addr_o=pc, both driven from registers with no combinational input paths.
- Per-cycle signals:
  - pop = valid_o & ready_i.
  - space = (count<2) | pop.
  - push = ce_r & space & ~redirect_i.
- Push:
  - Write {pc, rom_inst_i} at the tail.
  - pc <= pc + 32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- Stall: if ce_r & ~space & ~redirect_i, no push and pc holds, so the same address is re-presented.
- Pop: advance the head pointer.
- Count update: count += push - pop. Push and pop in the same cycle at count=2 is legal and leaves count=2.
- Redirect (has priority over push and pop):
  - count <= 0, pointers <= 0, pc <= {redirect_pc_i[31:2], 2'b00}.
  - The ROM word at the old pc is discarded.
  - A pop in the redirect cycle still completes from decode's view (head was valid and ready was high); the queue is emptied regardless.
  - valid_o=0 in the cycle after a redirect; the first target instruction becomes valid one cycle later (redirect-to-valid latency = 2 cycles).
- Steady state: with ready_i held at 1, one instruction is delivered per cycle. Fetch-to-valid latency = 1 cycle (registered queue).
- valid_o = (count != 0). inst_o and pc_o are read from the head entry, gated to `ZeroWord when empty.
- Reset mid-operation clears everything asynchronously; in-flight entries are lost.
- redirect_i while ce_r=0: pc is still loaded with the target; fetch begins once ce_r=1.

Decomposition:
- Existing shared include (defines.v) supplies `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable, `ChipDisable.
- New define for the shared include: `FetchQDepth 2.
- One natural sub-module: fetch_queue.
  - 2-entry, 64-bit wide synchronous FIFO.
  - Ports: push, pop, flush, din, dout, empty, full.
  - Same clk/rst convention as the parent.
- PC and ce logic stay in fetch_unit.

Test Plan:
- Reset release with ready_i=1, ROM preloaded with mem[i]=i+32'h100:
  - rom_ce_o rises 1 cycle after rst deasserts.
  - valid_o rises one cycle later with pc_o=0, inst_o=32'h100.
  - Subsequent cycles give pc_o=4,8,12 with inst_o=32'h101,32'h102,32'h103.
- Backpressure: ready_i=0 for 5 cycles after first valid:
  - count saturates at 2 (pc_o=0 and 4 queued); rom_addr_o holds at 8.
  - On ready_i=1, entries arrive in order 0,4,8 with no loss or duplicate.
- Redirect while full: count=2, redirect_i=1 with redirect_pc_i=32'h0000_0043:
  - valid_o=0 next cycle.
  - Cycle after that: pc_o=32'h40, inst_o=mem[16].
- Simultaneous push and pop at full with ready_i toggling 1/0: no overflow, strictly increasing pc_o sequence.
- Wrap-around: redirect to 32'hFFFF_FFFC then free-run; pc_o sequence is FFFF_FFFC, 0000_0000, 0000_0004.
- Asynchronous reset asserted mid-stream between clock edges:
  - valid_o=0, rom_ce_o=0 and rom_addr_o=RESET_PC immediately, without waiting for a clock edge.
  - Recovery matches the first scenario.
